// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel registered selector / round-robin arbiter.
// Define RR_MUX_ARB_LOCK_EN to hold a grant until the source's last beat.
module rr_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW = SELW + 1;

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_g;
  logic            rr_hit;
  logic            fx_hit;
  logic [SELW-1:0] gnt;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_nxt;
  logic            load;
  logic            xfer;
  logic            adv;
  logic [SELW:0]   idx;

  assign load = !out_valid || out_ready;

  // Walk down so the lowest offset from rr_ptr wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + PW'(k);
      if (idx >= PW'(N)) idx = idx - PW'(N);
      if (in_valid[idx[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_g   = idx[SELW-1:0];
      end
    end
  end

  assign fx_hit = ({1'b0, sel} < PW'(N)) && in_valid[sel];

`ifdef RR_MUX_ARB_LOCK_EN
  logic            lock_q;
  logic [SELW-1:0] lock_ch;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    unique case (1'b1)
      lock_q: begin
        gnt     = lock_ch;
        gnt_vld = in_valid[lock_ch];
      end
      !lock_q && mode: begin
        gnt     = rr_g;
        gnt_vld = rr_hit;
      end
      !lock_q && !mode: begin
        gnt     = sel;
        gnt_vld = fx_hit;
      end
      default: ;
    endcase
  end

  assign adv = xfer && (mode || lock_q) && in_last[gnt];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock_q  <= !in_last[gnt];
      lock_ch <= gnt;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    unique case (1'b1)
      mode: begin
        gnt     = rr_g;
        gnt_vld = rr_hit;
      end
      !mode: begin
        gnt     = sel;
        gnt_vld = fx_hit;
      end
      default: ;
    endcase
  end

  assign adv = xfer && mode;
`endif

  assign xfer = gnt_vld && load && !Reset;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  assign gnt_nxt = (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= in_data[gnt*WIDTH +: WIDTH];
          out_sel  <= gnt;
        end
      end
      if (adv) rr_ptr <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed checks of rr_mux_arb (N=4 and N=3 instances).
// Exercises fixed select, round-robin, backpressure, drain and reset.
module tb_rr_mux_arb;

  logic         Clk;
  logic         Reset;

  logic         mode;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic         b_mode;
  logic [1:0]   b_sel;
  logic [95:0]  b_in_data;
  logic [2:0]   b_in_valid;
  logic [2:0]   b_in_last;
  logic [2:0]   b_in_ready;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_sel;
  logic         b_out_valid;
  logic         b_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  rr_mux_arb #(.WIDTH(32), .N(4)) dut (
    .Clk(Clk), .Reset(Reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_mux_arb #(.WIDTH(32), .N(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] chd(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] bhd(input int i);
    return 32'hB0B0_0000 + 32'(i);
  endfunction

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    mode = 1'b1;
    in_valid = 4'hF;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0000", in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_out: got v=%b d=%h s=%0d want 0/0/0",
               out_valid, out_data, out_sel);
    end
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_out_sel !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_out3: got v=%b s=%0d want 0/0", b_out_valid, b_out_sel);
    end
    @(negedge Clk);
    in_valid = 4'h0;
    Reset = 1'b0;
  endtask

  task automatic test_fixed();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      mode = 1'b0;
      sel = 2'd2;
      in_valid = 4'hF;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0100) begin
        n_bad++;
        $display("FAIL fix_ready%0d: got %b want 0100", c, in_ready);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== chd(2)) begin
        n_bad++;
        $display("FAIL fix_out%0d: got v=%b s=%0d d=%h want 1/2/%h",
                 c, out_valid, out_sel, out_data, chd(2));
      end
    end
    @(negedge Clk);
    sel = 2'd1;
    in_valid = 4'b1101;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL fix_idle_ready: got %b want 0000", in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== chd(2)) begin
      n_bad++;
      $display("FAIL fix_idle_out: got v=%b d=%h want 0/%h",
               out_valid, out_data, chd(2));
    end
  endtask

  task automatic test_rr();
    int exp_s [5] = '{0, 1, 2, 3, 0};
    logic [3:0] er;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      mode = 1'b1;
      in_valid = 4'hF;
      out_ready = 1'b1;
      er = 4'b0001 << exp_s[c];
      #1;
      n_cmp++;
      if (in_ready !== er) begin
        n_bad++;
        $display("FAIL rr_ready%0d: got %b want %b", c, in_ready, er);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_sel !== 2'(exp_s[c]) ||
          out_data !== chd(exp_s[c])) begin
        n_bad++;
        $display("FAIL rr_out%0d: got v=%b s=%0d d=%h want 1/%0d/%h",
                 c, out_valid, out_sel, out_data, exp_s[c], chd(exp_s[c]));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_ready%0d: got %b want 0000", c, in_ready);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== chd(0)) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b s=%0d d=%h want 1/0/%h",
                 c, out_valid, out_sel, out_data, chd(0));
      end
    end
    @(negedge Clk);
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_rel_ready: got %b want 0010", in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== chd(1)) begin
      n_bad++;
      $display("FAIL bp_rel_out: got v=%b s=%0d d=%h want 1/1/%h",
               out_valid, out_sel, out_data, chd(1));
    end
  endtask

  task automatic test_drain();
    @(negedge Clk);
    in_valid = 4'h0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL drain_ready: got %b want 0000", in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== chd(1) || out_sel !== 2'd1) begin
      n_bad++;
      $display("FAIL drain_out: got v=%b s=%0d d=%h want 0/1/%h",
               out_valid, out_sel, out_data, chd(1));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    in_valid = 4'b0010;
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
      n_bad++;
      $display("FAIL rm_pre: got v=%b s=%0d want 1/1", out_valid, out_sel);
    end
    @(negedge Clk);
    Reset = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL rm_ready: got %b want 0000", in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rm_out: got v=%b s=%0d d=%h want 0/0/0",
               out_valid, out_sel, out_data);
    end
    @(negedge Clk);
    Reset = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL rm_first_ready: got %b want 0001", in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== chd(0)) begin
      n_bad++;
      $display("FAIL rm_first_out: got v=%b s=%0d d=%h want 1/0/%h",
               out_valid, out_sel, out_data, chd(0));
    end
  endtask

  task automatic test_no_lock();
    int exp_s [3] = '{1, 2, 0};
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      in_valid = 4'b0111;
      in_last = (c == 2) ? 4'b0010 : 4'b0000;
      @(posedge Clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_sel !== 2'(exp_s[c])) begin
        n_bad++;
        $display("FAIL nolock%0d: got v=%b s=%0d want 1/%0d",
                 c, out_valid, out_sel, exp_s[c]);
      end
    end
    @(negedge Clk);
    in_valid = 4'h0;
    in_last = 4'h0;
    @(posedge Clk); #1;
  endtask

  task automatic test_n3();
    int exp_s [4] = '{0, 2, 0, 2};
    logic [2:0] er;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      b_mode = 1'b1;
      b_in_valid = 3'b101;
      b_out_ready = 1'b1;
      er = 3'b001 << exp_s[c];
      #1;
      n_cmp++;
      if (b_in_ready !== er) begin
        n_bad++;
        $display("FAIL n3_ready%0d: got %b want %b", c, b_in_ready, er);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_out_sel !== 2'(exp_s[c]) ||
          b_out_data !== bhd(exp_s[c])) begin
        n_bad++;
        $display("FAIL n3_out%0d: got v=%b s=%0d d=%h want 1/%0d/%h",
                 c, b_out_valid, b_out_sel, b_out_data, exp_s[c], bhd(exp_s[c]));
      end
    end
    @(negedge Clk);
    b_mode = 1'b0;
    b_sel = 2'd3;
    b_in_valid = 3'b111;
    #1;
    n_cmp++;
    if (b_in_ready !== 3'b000) begin
      n_bad++;
      $display("FAIL n3_sel3_ready: got %b want 000", b_in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (b_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL n3_sel3_out: got v=%b want 0", b_out_valid);
    end
    @(negedge Clk);
    b_sel = 2'd2;
    #1;
    n_cmp++;
    if (b_in_ready !== 3'b100) begin
      n_bad++;
      $display("FAIL n3_sel2_ready: got %b want 100", b_in_ready);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (b_out_valid !== 1'b1 || b_out_sel !== 2'd2 || b_out_data !== bhd(2)) begin
      n_bad++;
      $display("FAIL n3_sel2_out: got v=%b s=%0d d=%h want 1/2/%h",
               b_out_valid, b_out_sel, b_out_data, bhd(2));
    end
    @(negedge Clk);
    b_in_valid = 3'b000;
  endtask

  initial begin
    Reset = 1'b1;
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'h0;
    in_last = 4'h0;
    out_ready = 1'b1;
    b_mode = 1'b0;
    b_sel = 2'd0;
    b_in_valid = 3'b000;
    b_in_last = 3'b000;
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = chd(i);
    for (int i = 0; i < 3; i++) b_in_data[i*32 +: 32] = bhd(i);
    @(posedge Clk);
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_no_lock();
    test_n3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
